// File: rtl/enemy_bank.sv
// Bank of N bouncing square enemies: config store, tick-driven serial update engine, player
// collision and a valid/ready snapshot stream. Define ENEMY_ACCEL_EN for per-bounce speed-up.
module enemy_bank #(
   parameter int unsigned N        = 4,
   parameter int unsigned IDX_W    = 2,
   parameter int unsigned X_W      = 8,
   parameter int unsigned Y_W      = 7,
   parameter int unsigned SCREEN_W = 160,
   parameter int unsigned SCREEN_H = 120,
   parameter int unsigned SIZE_W   = 3,
   parameter int unsigned PLAYER_W = 3,
   parameter int unsigned RATE_DIV = 1000000
`ifdef ENEMY_ACCEL_EN
   ,
   parameter int unsigned RATE_STEP = 50000,
   parameter int unsigned RATE_MIN  = 250000
`endif
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              play_i,
   input  logic              load_level_i,
   input  logic              cfg_we_i,
   input  logic [IDX_W-1:0]  cfg_idx_i,
   input  logic              cfg_en_i,
   input  logic [X_W-1:0]    cfg_x_i,
   input  logic [Y_W-1:0]    cfg_y_i,
   input  logic [SIZE_W-1:0] cfg_w_i,
   input  logic [2:0]        cfg_dx_i,
   input  logic [2:0]        cfg_dy_i,
   input  logic              cfg_left_i,
   input  logic              cfg_up_i,
   input  logic [X_W-1:0]    player_x_i,
   input  logic [Y_W-1:0]    player_y_i,
   input  logic              draw_req_i,
   input  logic              draw_ready_i,
   output logic              draw_valid_o,
   output logic [IDX_W-1:0]  draw_idx_o,
   output logic              draw_en_o,
   output logic [X_W-1:0]    draw_x_o,
   output logic [Y_W-1:0]    draw_y_o,
   output logic [SIZE_W-1:0] draw_w_o,
   output logic              draw_last_o,
   output logic              move_o,
   output logic              player_hit_o,
   output logic [IDX_W-1:0]  hit_idx_o,
   output logic              busy_o
);

   localparam int unsigned    CNT_W   = $clog2(RATE_DIV + 1);
   localparam logic [X_W:0]   ScrW    = (X_W + 1)'(SCREEN_W);
   localparam logic [Y_W:0]   ScrH    = (Y_W + 1)'(SCREEN_H);
   localparam logic [X_W:0]   PlW_X   = (X_W + 1)'(PLAYER_W);
   localparam logic [Y_W:0]   PlW_Y   = (Y_W + 1)'(PLAYER_W);
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

   typedef struct packed {
      logic              en;
      logic [X_W-1:0]    x;
      logic [Y_W-1:0]    y;
      logic [SIZE_W-1:0] w;
      logic [2:0]        dx;
      logic [2:0]        dy;
      logic              left;
      logic              up;
   } entry_t;

   typedef enum logic [1:0] {StIdle, StUpdate, StStream} state_e;

   entry_t cfg_q  [N];
   entry_t live_q [N];
   entry_t cur, nxt;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period;
   logic             tick_pend_q, tick_pend_d;
   logic             draw_pend_q, draw_pend_d;
   logic             move_q, move_d;
   logic             hit_q, hit_d;
   logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
   logic             wrap, hit_now;

   logic [X_W:0] xe, wx, dxe, nx, pxe;
   logic [Y_W:0] ye, wy, dye, ny, pye;

   assign cur = live_q[idx_q];

   // Motion and collision for the entry currently addressed by idx_q, one bit wider than storage.
   always_comb begin
      xe  = {1'b0, cur.x};
      ye  = {1'b0, cur.y};
      wx  = {{(X_W + 1 - SIZE_W){1'b0}}, cur.w};
      wy  = {{(Y_W + 1 - SIZE_W){1'b0}}, cur.w};
      dxe = {{(X_W - 2){1'b0}}, cur.dx};
      dye = {{(Y_W - 2){1'b0}}, cur.dy};
      pxe = {1'b0, player_x_i};
      pye = {1'b0, player_y_i};
      nxt = cur;
      nx  = xe;
      ny  = ye;
      if (cur.left) begin
         if (xe <= dxe) begin
            nx       = '0;
            nxt.left = 1'b0;
         end else begin
            nx = xe - dxe;
         end
      end else if (xe + wx + dxe >= ScrW) begin
         nx       = ScrW - wx;
         nxt.left = 1'b1;
      end else begin
         nx = xe + dxe;
      end
      if (cur.up) begin
         if (ye <= dye) begin
            ny     = '0;
            nxt.up = 1'b0;
         end else begin
            ny = ye - dye;
         end
      end else if (ye + wy + dye >= ScrH) begin
         ny     = ScrH - wy;
         nxt.up = 1'b1;
      end else begin
         ny = ye + dye;
      end
      nxt.x   = nx[X_W-1:0];
      nxt.y   = ny[Y_W-1:0];
      hit_now = cur.en && (nx < pxe + PlW_X) && (pxe < nx + wx) &&
                (ny < pye + PlW_Y) && (pye < ny + wy);
   end

`ifdef ENEMY_ACCEL_EN
   logic [CNT_W-1:0] period_q, period_d;
   logic             bounce_q, bounce_d;
   logic             bounce_now;

   // A direction flip only ever comes from an edge bounce.
   assign bounce_now = cur.en && ((nxt.left ^ cur.left) || (nxt.up ^ cur.up));
   assign period     = period_q;

   always_comb begin
      period_d = period_q;
      bounce_d = bounce_q;
      if (load_level_i) begin
         period_d = CNT_W'(RATE_DIV);
         bounce_d = 1'b0;
      end else if (state_q == StUpdate) begin
         bounce_d = bounce_q | bounce_now;
         if (idx_q == LastIdx) begin
            bounce_d = 1'b0;
            if (bounce_q || bounce_now) begin
               period_d = (32'(period_q) >= RATE_MIN + RATE_STEP) ?
                          period_q - CNT_W'(RATE_STEP) : CNT_W'(RATE_MIN);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         period_q <= CNT_W'(RATE_DIV);
         bounce_q <= 1'b0;
      end else begin
         period_q <= period_d;
         bounce_q <= bounce_d;
      end
   end
`else
   assign period = CNT_W'(RATE_DIV);
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      wrap        = 1'b0;
      move_d      = 1'b0;
      hit_d       = hit_q;
      hit_idx_d   = hit_idx_q;
      if (play_i) begin
         if (cnt_q >= period - CNT_W'(1)) begin
            cnt_d = '0;
            wrap  = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      tick_pend_d = tick_pend_q | wrap;
      draw_pend_d = draw_pend_q | draw_req_i;
      unique case (state_q)
         StIdle: begin
            if (tick_pend_q) begin
               state_d     = StUpdate;
               idx_d       = '0;
               tick_pend_d = wrap;
            end else if (draw_pend_q) begin
               state_d     = StStream;
               idx_d       = '0;
               draw_pend_d = draw_req_i;
            end
         end
         StUpdate: begin
            if (hit_now && !hit_q) begin
               hit_d     = 1'b1;
               hit_idx_d = idx_q;
            end
            if (idx_q == LastIdx) begin
               state_d = StIdle;
               move_d  = 1'b1;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         StStream: begin
            if (draw_ready_i) begin
               if (idx_q == LastIdx) state_d = StIdle;
               else                  idx_d   = idx_q + IDX_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
      if (load_level_i) begin
         state_d     = StIdle;
         idx_d       = '0;
         cnt_d       = '0;
         tick_pend_d = 1'b0;
         draw_pend_d = 1'b0;
         move_d      = 1'b0;
         hit_d       = 1'b0;
         hit_idx_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         cnt_q       <= '0;
         tick_pend_q <= 1'b0;
         draw_pend_q <= 1'b0;
         move_q      <= 1'b0;
         hit_q       <= 1'b0;
         hit_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         tick_pend_q <= tick_pend_d;
         draw_pend_q <= draw_pend_d;
         move_q      <= move_d;
         hit_q       <= hit_d;
         hit_idx_q   <= hit_idx_d;
      end
   end

   // The load copies the config as it stood before any same-cycle config write.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < N; i++) begin
            cfg_q[i]  <= '0;
            live_q[i] <= '0;
         end
      end else begin
         if (cfg_we_i) begin
            cfg_q[cfg_idx_i] <= {cfg_en_i, cfg_x_i, cfg_y_i, cfg_w_i, cfg_dx_i, cfg_dy_i,
                                 cfg_left_i, cfg_up_i};
         end
         if (load_level_i) begin
            for (int i = 0; i < N; i++) live_q[i] <= cfg_q[i];
         end else if (state_q == StUpdate && cur.en) begin
            live_q[idx_q] <= nxt;
         end
      end
   end

   always_comb begin
      draw_valid_o = 1'b0;
      draw_idx_o   = '0;
      draw_en_o    = 1'b0;
      draw_x_o     = '0;
      draw_y_o     = '0;
      draw_w_o     = '0;
      draw_last_o  = 1'b0;
      if (state_q == StStream) begin
         draw_valid_o = 1'b1;
         draw_idx_o   = idx_q;
         draw_en_o    = cur.en;
         draw_x_o     = cur.x;
         draw_y_o     = cur.y;
         draw_w_o     = cur.w;
         draw_last_o  = (idx_q == LastIdx);
      end
   end

   assign move_o       = move_q;
   assign player_hit_o = hit_q;
   assign hit_idx_o    = hit_idx_q;
   assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_enemy_bank.sv
// Scoreboard bench for enemy_bank: a behavioural model predicts snapshots and hit status,
// a negedge monitor pops expected stream entries as the DUT transfers them.
module tb_enemy_bank;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       play = 1'b0, load_level = 1'b0, cfg_we = 1'b0;
   logic [1:0] cfg_idx = '0;
   logic       cfg_en = 1'b0, cfg_left = 1'b0, cfg_up = 1'b0;
   logic [7:0] cfg_x = '0, player_x = '0;
   logic [6:0] cfg_y = '0, player_y = '0;
   logic [2:0] cfg_w = '0, cfg_dx = '0, cfg_dy = '0;
   logic       draw_req = 1'b0, draw_ready = 1'b0;
   logic       draw_valid, draw_en, draw_last, move, player_hit, busy;
   logic [1:0] draw_idx, hit_idx;
   logic [7:0] draw_x;
   logic [6:0] draw_y;
   logic [2:0] draw_w;

   always #5 clk = ~clk;

   enemy_bank #(.RATE_DIV(4)) dut (
      .clk(clk), .resetn(resetn), .play_i(play), .load_level_i(load_level),
      .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_en_i(cfg_en), .cfg_x_i(cfg_x),
      .cfg_y_i(cfg_y), .cfg_w_i(cfg_w), .cfg_dx_i(cfg_dx), .cfg_dy_i(cfg_dy),
      .cfg_left_i(cfg_left), .cfg_up_i(cfg_up), .player_x_i(player_x), .player_y_i(player_y),
      .draw_req_i(draw_req), .draw_ready_i(draw_ready), .draw_valid_o(draw_valid),
      .draw_idx_o(draw_idx), .draw_en_o(draw_en), .draw_x_o(draw_x), .draw_y_o(draw_y),
      .draw_w_o(draw_w), .draw_last_o(draw_last), .move_o(move), .player_hit_o(player_hit),
      .hit_idx_o(hit_idx), .busy_o(busy)
   );

   // Reference model: c_* is the config store, m_* the live enemies.
   int c_en[N], c_x[N], c_y[N], c_w[N], c_dx[N], c_dy[N], c_left[N], c_up[N];
   int m_en[N], m_x[N], m_y[N], m_w[N], m_dx[N], m_dy[N], m_left[N], m_up[N];
   int m_hit = 0, m_hit_idx = 0, pl_x = 0, pl_y = 0;

   int checks = 0, errors = 0;
   int q[$];
   int move_cnt = 0, stream_done = 0, after_last = 0, ready_mode = 0, rcnt = 0;
   bit busy_expect = 1'b0, stall_prev = 1'b0;
   logic [31:0] prev_vec = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pack(input int idx, en, x, y, w, last);
      return (en << 21) | (idx << 19) | (x << 11) | (y << 4) | (w << 1) | last;
   endfunction

   function automatic logic [31:0] cur_vec();
      return {9'd0, draw_valid, 22'(pack(int'(draw_idx), int'(draw_en), int'(draw_x),
                                          int'(draw_y), int'(draw_w), int'(draw_last)))};
   endfunction

   // One axis of bounce motion in plain integer arithmetic.
   task automatic step(input int p, d, w, lim, neg, output int np, output int nneg);
      if (neg != 0) begin
         if (p - d <= 0) begin np = 0; nneg = 0; end
         else begin np = p - d; nneg = 1; end
      end else begin
         if (p + w + d >= lim) begin np = lim - w; nneg = 1; end
         else begin np = p + d; nneg = 0; end
      end
   endtask

   task automatic apply_pass();
      for (int i = 0; i < N; i++) begin
         if (m_en[i] != 0) begin
            step(m_x[i], m_dx[i], m_w[i], 160, m_left[i], m_x[i], m_left[i]);
            step(m_y[i], m_dy[i], m_w[i], 120, m_up[i], m_y[i], m_up[i]);
            if (m_hit == 0 && m_x[i] < pl_x + 3 && pl_x < m_x[i] + m_w[i] &&
                m_y[i] < pl_y + 3 && pl_y < m_y[i] + m_w[i]) begin
               m_hit = 1;
               m_hit_idx = i;
            end
         end
      end
   endtask

   task automatic model_load();
      for (int i = 0; i < N; i++) begin
         m_en[i] = c_en[i]; m_x[i] = c_x[i]; m_y[i] = c_y[i]; m_w[i] = c_w[i];
         m_dx[i] = c_dx[i]; m_dy[i] = c_dy[i]; m_left[i] = c_left[i]; m_up[i] = c_up[i];
      end
      m_hit = 0;
      m_hit_idx = 0;
   endtask

   task automatic tick_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_player(input int x, y);
      player_x = 8'(x); player_y = 7'(y); pl_x = x; pl_y = y;
   endtask

   task automatic cfg_write(input int i, en, x, y, w, dx, dy, left, up, input bit with_load);
      cfg_idx = 2'(i); cfg_en = 1'(en); cfg_x = 8'(x); cfg_y = 7'(y); cfg_w = 3'(w);
      cfg_dx = 3'(dx); cfg_dy = 3'(dy); cfg_left = 1'(left); cfg_up = 1'(up);
      cfg_we = 1'b1;
      load_level = with_load;
      tick_cyc();
      cfg_we = 1'b0;
      load_level = 1'b0;
      if (with_load) model_load();
      c_en[i] = en; c_x[i] = x; c_y[i] = y; c_w[i] = w;
      c_dx[i] = dx; c_dy[i] = dy; c_left[i] = left; c_up[i] = up;
   endtask

   task automatic do_load();
      load_level = 1'b1;
      tick_cyc();
      load_level = 1'b0;
      model_load();
   endtask

   task automatic wait_pass(input int exp);
      int n;
      n = 0;
      while (move_cnt < exp && n < 50) begin tick_cyc(); n++; end
      n = 0;
      while (busy && n < 50) begin tick_cyc(); n++; end
      repeat (3) tick_cyc();
      check("move_count", move_cnt, exp);
      apply_pass();
      check("player_hit", {31'd0, player_hit}, m_hit);
      check("hit_idx", {30'd0, hit_idx}, m_hit_idx);
   endtask

   // Four counted cycles from a frozen counter wrap it exactly once.
   task automatic one_pass();
      int exp;
      exp = move_cnt + 1;
      play = 1'b1;
      repeat (4) tick_cyc();
      play = 1'b0;
      wait_pass(exp);
   endtask

   task automatic stream(input int mode, input bit with_tick);
      int done, exp, n;
      for (int i = 0; i < N; i++)
         q.push_back(pack(i, m_en[i], m_x[i], m_y[i], m_w[i], (i == N - 1) ? 1 : 0));
      done = stream_done;
      exp = move_cnt + 1;
      ready_mode = mode;
      busy_expect = with_tick;
      draw_req = 1'b1;
      tick_cyc();
      draw_req = 1'b0;
      if (with_tick) begin
         play = 1'b1;
         repeat (4) tick_cyc();
         play = 1'b0;
      end
      n = 0;
      while (stream_done == done && n < 200) begin tick_cyc(); n++; end
      check("stream_done", stream_done, done + 1);
      repeat (3) tick_cyc();
      if (with_tick) wait_pass(exp);
      check("queue_empty", q.size(), 0);
   endtask

   always @(posedge clk) begin
      #1;
      rcnt++;
      case (ready_mode)
         0: draw_ready = 1'b1;
         1: draw_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
         default: draw_ready = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge clk) begin
      if (resetn) begin
         if (move) move_cnt++;
         if (after_last == 2) begin
            if (busy_expect) begin
               check("update_after_stream", {31'd0, busy}, 1);
               busy_expect = 1'b0;
            end
            after_last = 0;
         end
         if (after_last == 1) begin
            check("valid_after_last", {31'd0, draw_valid}, 0);
            after_last = 2;
         end
         if (stall_prev) check("hold_while_stalled", cur_vec(), prev_vec);
         if (draw_valid && draw_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_entry: got 0x%0h expected none", cur_vec());
            end else begin
               check("draw_entry", cur_vec(), {9'd0, 1'b1, 22'(q.pop_front())});
            end
            if (draw_last) begin
               stream_done++;
               after_last = 1;
            end
         end
         stall_prev = draw_valid && !draw_ready;
         prev_vec = cur_vec();
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      // Reset with a draw request held: everything must read zero.
      resetn = 1'b0;
      draw_req = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_draw", {draw_valid, draw_idx, draw_en, draw_x, draw_y, draw_w, draw_last}, 0);
      check("rst_status", {move, player_hit, hit_idx}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      draw_req = 1'b0;
      tick_cyc();
      stream(0, 1'b0);

      // Straight motion and edge bounces on all four sides.
      set_player(100, 100);
      cfg_write(0, 1, 10, 20, 2, 2, 1, 0, 0, 1'b0);
      cfg_write(1, 1, 155, 116, 3, 3, 2, 0, 0, 1'b0);
      cfg_write(2, 1, 1, 50, 1, 2, 0, 1, 0, 1'b0);
      cfg_write(3, 1, 2, 60, 1, 2, 0, 1, 0, 1'b0);
      do_load();
      one_pass();
      stream(1, 1'b0);
      one_pass();
      stream(1, 1'b0);

      // Collision; the load shares a cycle with a config write and must see the old entry 0.
      set_player(80, 115);
      cfg_write(0, 0, 0, 0, 1, 0, 0, 0, 0, 1'b0);
      cfg_write(1, 0, 0, 0, 1, 0, 0, 0, 0, 1'b0);
      cfg_write(2, 1, 76, 112, 3, 2, 1, 0, 0, 1'b0);
      cfg_write(3, 1, 86, 115, 3, 3, 0, 1, 0, 1'b0);
      cfg_write(0, 1, 5, 5, 2, 1, 1, 0, 0, 1'b1);
      one_pass();
      one_pass();
      stream(1, 1'b0);
      do_load();
      tick_cyc();
      check("hit_cleared", {31'd0, player_hit}, 0);
      check("hit_idx_cleared", {30'd0, hit_idx}, 0);

      // A tick landing mid-stream must wait for the stream to finish.
      stream(1, 1'b1);

      repeat (6) begin
         set_player($urandom_range(0, 157), $urandom_range(0, 117));
         for (int i = 0; i < N; i++) begin
            w = $urandom_range(1, 7);
            cfg_write(i, ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 160 - w),
                      $urandom_range(0, 120 - w), w, $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 1), $urandom_range(0, 1),
                      (i == N - 1) && ($urandom_range(0, 1) == 1));
         end
         do_load();
         repeat ($urandom_range(1, 3)) one_pass();
         stream($urandom_range(0, 2), 1'b0);
         one_pass();
         stream(2, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/enemy_bank.md
Name: enemy_bank

Overview:
- N-channel successor to the single-enemy controller: one block owns up to N bouncing square enemies.
- Holds a per-enemy start configuration, advances all enemies on a shared rate tick with a sequential one-enemy-per-cycle update engine, and detects player collision.
- Streams a coherent position snapshot to the VGA draw FSM over a valid/ready handshake.
- Sits between the level loader (cfg_*, load_level) and the draw/game-state logic.

Parameters:
N, 4, number of enemy channels
IDX_W, 2, index width, must satisfy 2**IDX_W >= N
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
SCREEN_W, 160, screen width in pixels
SCREEN_H, 120, screen height in pixels
SIZE_W, 3, enemy width field width
PLAYER_W, 3, player square size in pixels
RATE_DIV, 1000000, clk cycles per movement tick
RATE_STEP, 50000, per-bounce period reduction (optional feature only)
RATE_MIN, 250000, period floor (optional feature only)

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
play  in  1  enables the tick counter
load_level  in  1  copy config into live state, clear hit
cfg_we  in  1  write config entry cfg_idx
cfg_idx  in  IDX_W  config entry index
cfg_en  in  1  enemy enabled
cfg_x  in  X_W  start x (top-left)
cfg_y  in  Y_W  start y (top-left)
cfg_w  in  SIZE_W  enemy width
cfg_dx  in  3  x step per tick
cfg_dy  in  3  y step per tick
cfg_left  in  1  initial direction left
cfg_up  in  1  initial direction up
player_x  in  X_W  player top-left x
player_y  in  Y_W  player top-left y
draw_req  in  1  request snapshot stream (pulse)
draw_ready  in  1  consumer accepts current entry
draw_valid  out  1  stream entry valid
draw_idx  out  IDX_W  entry index
draw_en  out  1  entry enabled
draw_x  out  X_W  entry x
draw_y  out  Y_W  entry y
draw_w  out  SIZE_W  entry width
draw_last  out  1  entry is index N-1
move  out  1  one-cycle pulse after each completed update pass
player_hit  out  1  sticky collision flag
hit_idx  out  IDX_W  lowest index that caused the first hit
busy  out  1  FSM not in IDLE

Behaviour:
- Reset:
  - All outputs 0.
  - Config and live entries cleared, so every enemy has en=0.
  - Counter 0, FSM IDLE, pending flags 0.
- Priority: resetn > load_level > everything else. cfg_we is independent of load_level. When both occur in the same cycle, the load uses the pre-write config contents.
- load_level:
  - Copies every config entry into live state.
  - Clears the counter, player_hit, hit_idx and pending flags.
  - FSM goes to IDLE and draw_valid drops to 0; any in-flight stream is aborted.
- Counter:
  - Increments only while play=1.
  - At RATE_DIV-1 it wraps to 0 and raises tick_pend. tick_pend saturates at 1; extra ticks are dropped.
- FSM states: IDLE, UPDATE, STREAM.
  - IDLE -> UPDATE when tick_pend=1. This has priority over draw_pend.
  - IDLE -> STREAM when draw_pend=1.
  - draw_req in any state sets draw_pend.
- UPDATE:
  - Visits idx 0..N-1, one per cycle, so a pass takes N cycles. Disabled entries are skipped in place but still consume their cycle.
  - move pulses the cycle after idx N-1 is visited, then the FSM returns to IDLE.
  - tick_pend is cleared on entry to UPDATE.
- Motion arithmetic: evaluate at X_W+1 / Y_W+1 bits with no underflow. Edge checks:
  - Left: if x <= dx then x=0 and direction flips to right; else x=x-dx.
  - Right: if x+w+dx >= SCREEN_W then x=SCREEN_W-w and direction flips to left; else x=x+dx.
  - y axis is identical, using dy and SCREEN_H.
- Collision:
  - Evaluated in the UPDATE cycle for each enabled enemy, using its new position. The test is an inclusive box overlap between the enemy (x..x+w-1, y..y+w-1) and the player (px..px+PLAYER_W-1, py..py+PLAYER_W-1).
  - When player_hit=0, a hit sets player_hit=1 and hit_idx on the next cycle. Later hits change neither output.
- STREAM:
  - Clears draw_pend on entry and emits N entries, idx 0..N-1.
  - While draw_valid=1 and draw_ready=0, all draw_* outputs hold stable.
  - A transfer happens on valid&ready. The next entry is presented the following cycle; there are no bubbles while ready is held at 1.
  - After the draw_last transfer, draw_valid=0 and the FSM returns to IDLE.
  - Ticks arriving mid-stream stay pending, so the snapshot is never torn.
- play=0 freezes only the counter. An in-progress UPDATE or STREAM completes normally.

Optional Feature:
ENEMY_ACCEL_EN:
- Defined:
  - The tick period is held in a register, initialised to RATE_DIV on reset and on load_level.
  - On each UPDATE pass containing at least one bounce, the period drops by RATE_STEP, clamped at RATE_MIN.
- Undefined: the period is the constant RATE_DIV and no period register exists.

Test Plan:
- Reset: hold resetn=0 for 2 cycles with draw_req=1 -> all outputs 0, busy=0; after release draw_req streams 4 entries, all with draw_en=0.
- Straight motion (RATE_DIV=4, play=1): enemy0 x=10, y=20, dx=2, dy=1, right/down -> move every 4+ cycles, x=12/y=21 after first pass, x=14/y=22 after second.
- Right/bottom bounce: enemy1 x=155, w=3, dx=3, right -> x=157 and left; next pass x=154. Enemy y=116, w=3, dy=2, down -> y=117 and up.
- Left bounce: x=1, dx=2, left -> x=0 and right; next pass x=2. Also x=2, dx=2 -> x=0 and flips.
- Collision: player (80,115), enemy2 lands at (78,113) w=3 -> player_hit=1, hit_idx=2; enemy3 hits later -> hit_idx stays 2; load_level clears both.
- Stream: draw_req with draw_ready toggling 1,0,0,1 -> each entry held while ready=0, idx 0..3, draw_last on idx 3; a tick during the stream -> UPDATE starts the cycle after the last transfer.
